// File: rtl/cheri_branch_sequencer.sv
// cheri_branch_sequencer
// Sequences control-flow instructions into the CHERI-aware branch unit.
// Plain branches, JAL, JALR and CJALR fire the branch unit one cycle after
// issue. CINVOKE first requests a CLU check, waits for the result, then fires
// the branch unit with the CLU exception held stable. One instruction is in
// flight at a time; the result is held on the writeback port until accepted.
// Optional feature macro: CHERI_BRANCH_CLU_TIMEOUT_EN adds a CLU response
// timeout that raises a capability exception after CLU_TIMEOUT cycles.
module cheri_branch_sequencer #(
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned CLU_TIMEOUT   = 16,
  parameter int unsigned EXC_W         = 129
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
  input  logic                     issue_is_cinvoke_i,
  output logic                     clu_req_o,
  input  logic                     clu_valid_i,
  input  logic [EXC_W-1:0]         clu_exception_i,
  output logic                     bu_valid_o,
  output logic [EXC_W-1:0]         bu_clu_exception_o,
  input  logic                     bu_resolve_i,
  input  logic                     bu_mispredict_i,
  input  logic                     bu_exception_valid_i,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic                     wb_exception_o,
  output logic                     wb_mispredict_o,
  input  logic                     wb_ready_i,
  output logic                     timeout_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CLU = 2'd1,
    FIRE     = 2'd2,
    WB       = 2'd3
  } state_t;

  state_t                   state;
  logic [TRANS_ID_BITS-1:0] trans_id;
  logic                     accept;
  logic                     timeout;

  // An offer is taken only in IDLE and only when neither reset nor flush is active.
  assign accept    = rst_ni & ~flush_i & (state == IDLE) & issue_valid_i;
  // The CLU registers this request, so it is raised in the accepting cycle itself.
  assign clu_req_o = accept & issue_is_cinvoke_i;

`ifdef CHERI_BRANCH_CLU_TIMEOUT_EN
  localparam int unsigned CNT_W = (CLU_TIMEOUT > 2) ? $clog2(CLU_TIMEOUT) : 1;
  localparam logic [63:0] CAP_EXCEPTION = 64'd28;

  logic [CNT_W-1:0] clu_cnt;

  // A real CLU response in the limit cycle wins over the timeout.
  assign timeout   = rst_ni & ~flush_i & (state == WAIT_CLU) & ~clu_valid_i &
                     (clu_cnt == CNT_W'(CLU_TIMEOUT - 1));
  assign timeout_o = timeout;

  // Wait counter: counts cycles spent in WAIT_CLU, zero in every other state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      clu_cnt <= '0;
    end else if (state != WAIT_CLU) begin
      clu_cnt <= '0;
    end else begin
      clu_cnt <= clu_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Main sequencer FSM with registered handshake outputs; flush behaves like reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      state              <= IDLE;
      trans_id           <= '0;
      issue_ready_o      <= 1'b1;
      bu_valid_o         <= 1'b0;
      bu_clu_exception_o <= '0;
      wb_valid_o         <= 1'b0;
      wb_trans_id_o      <= '0;
      wb_exception_o     <= 1'b0;
      wb_mispredict_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_valid_i) begin
            trans_id           <= issue_trans_id_i;
            bu_clu_exception_o <= '0;
            issue_ready_o      <= 1'b0;
            if (issue_is_cinvoke_i) begin
              state <= WAIT_CLU;
            end else begin
              state      <= FIRE;
              bu_valid_o <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT_CLU: begin
          if (clu_valid_i) begin
            bu_clu_exception_o <= clu_exception_i;
            bu_valid_o         <= 1'b1;
            state              <= FIRE;
`ifdef CHERI_BRANCH_CLU_TIMEOUT_EN
          end else if (timeout) begin
            bu_clu_exception_o <= EXC_W'({1'b1, CAP_EXCEPTION, 64'd0});
            bu_valid_o         <= 1'b1;
            state              <= FIRE;
`endif
          end else begin
            state <= WAIT_CLU;
          end
        end
        FIRE: begin
          // A missing resolve is a protocol error; the result is latched as zeros.
          bu_valid_o      <= 1'b0;
          wb_valid_o      <= 1'b1;
          wb_trans_id_o   <= trans_id;
          wb_mispredict_o <= bu_resolve_i & bu_mispredict_i;
          wb_exception_o  <= bu_resolve_i & bu_exception_valid_i;
          state           <= WB;
        end
        WB: begin
          if (wb_ready_i) begin
            wb_valid_o    <= 1'b0;
            issue_ready_o <= 1'b1;
            state         <= IDLE;
          end else begin
            state <= WB;
          end
        end
        default: begin
          state         <= IDLE;
          issue_ready_o <= 1'b1;
          bu_valid_o    <= 1'b0;
          wb_valid_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule
